// File: rtl/l2todr_req_rrarb.sv
// Round-robin merge of NREQ L2 request channels into l2todr_req.
// Two-entry output buffer keeps directory retry off the L2 side.
module l2todr_req_rrarb #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 64,
  parameter int IDX_W  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        l2todr_req_valid_in,
  output logic [NREQ-1:0]        l2todr_req_retry_in,
  input  logic [NREQ*DATA_W-1:0] l2todr_req_in,
  output logic                   l2todr_req_valid,
  input  logic                   l2todr_req_retry,
  output logic [DATA_W-1:0]      l2todr_req,
  output logic [IDX_W-1:0]       l2todr_req_src
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  src;
  } ent_t;

  typedef enum logic [1:0] {
    OCC0,
    OCC1,
    OCC2
  } occ_t;

  occ_t             occ_q, occ_d;
  ent_t             buf0_q, buf0_d;
  ent_t             buf1_q, buf1_d;
  ent_t             in_ent;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] gnt, gnt_inc;
  logic             any_v;
  logic             enq, deq;
  int               best;

  // pick the valid source closest to rr_q in rotating order
  always_comb begin
    gnt   = '0;
    any_v = 1'b0;
    best  = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (l2todr_req_valid_in[i] &&
          ((i + NREQ - int'(rr_q)) % NREQ) < best) begin
        best  = (i + NREQ - int'(rr_q)) % NREQ;
        gnt   = IDX_W'(i);
        any_v = 1'b1;
      end
    end
  end

  assign gnt_inc = (int'(gnt) == NREQ - 1) ?
                   '0 : gnt + IDX_W'(1);

  assign in_ent.data =
    l2todr_req_in[int'(gnt)*DATA_W +: DATA_W];
  assign in_ent.src  = gnt;

  assign enq = !reset && any_v && (occ_q != OCC2);
  assign deq = (occ_q != OCC0) && !l2todr_req_retry;

  // release only the granted source, and only when space exists
  always_comb begin
    l2todr_req_retry_in = '1;
    if (enq) l2todr_req_retry_in[gnt] = 1'b0;
  end

  assign l2todr_req_valid = !reset && (occ_q != OCC0);
  assign l2todr_req       = reset ? '0 : buf0_q.data;
  assign l2todr_req_src   = reset ? '0 : buf0_q.src;

  // buffer occupancy, entry movement and pointer advance
  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    rr_d   = rr_q;
    if (enq) rr_d = gnt_inc;
    case (occ_q)
      OCC0: begin
        if (enq) begin
          buf0_d = in_ent;
          occ_d  = OCC1;
        end
      end
      OCC1: begin
        if (enq && deq) begin
          buf0_d = in_ent;
        end else if (enq) begin
          buf1_d = in_ent;
          occ_d  = OCC2;
        end else if (deq) begin
          occ_d  = OCC0;
        end
      end
      OCC2: begin
        if (deq) begin
          buf0_d = buf1_q;
          occ_d  = OCC1;
        end
      end
      default: occ_d = OCC0;
    endcase
  end

  // state registers, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= OCC0;
      buf0_q <= '0;
      buf1_q <= '0;
      rr_q   <= '0;
    end else begin
      occ_q  <= occ_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      rr_q   <= rr_d;
    end
  end

endmodule

// File: tb/tb_l2todr_req_rrarb.sv
// Bench for l2todr_req_rrarb: queue model checked every cycle
// plus directed literal expectations.
module tb_l2todr_req_rrarb;

  localparam int NREQ   = 4;
  localparam int DATA_W = 64;
  localparam int IDX_W  = 2;
  localparam logic [NREQ-1:0] ALL1 = '1;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        l2todr_req_valid_in = '0;
  logic [NREQ-1:0]        l2todr_req_retry_in;
  logic [NREQ*DATA_W-1:0] l2todr_req_in = '0;
  logic                   l2todr_req_valid;
  logic                   l2todr_req_retry = 1'b0;
  logic [DATA_W-1:0]      l2todr_req;
  logic [IDX_W-1:0]       l2todr_req_src;

  l2todr_req_rrarb #(
    .NREQ(NREQ),
    .DATA_W(DATA_W),
    .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .l2todr_req_valid_in(l2todr_req_valid_in),
    .l2todr_req_retry_in(l2todr_req_retry_in),
    .l2todr_req_in(l2todr_req_in),
    .l2todr_req_valid(l2todr_req_valid),
    .l2todr_req_retry(l2todr_req_retry),
    .l2todr_req(l2todr_req),
    .l2todr_req_src(l2todr_req_src)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h t=%0t",
                  nm, act, exp, $time);
  endtask

  // source side
  logic [DATA_W-1:0] srcq [NREQ][$];
  logic [NREQ-1:0]   pop = '0;
  logic              rst_nxt = 1'b1;
  logic              dretry_nxt = 1'b0;

  always @(posedge clk) begin : drive
    logic [NREQ-1:0]        vin;
    logic [NREQ*DATA_W-1:0] din;
    #1;
    reset = rst_nxt;
    l2todr_req_retry = dretry_nxt;
    for (int i = 0; i < NREQ; i++) begin
      if (pop[i] && srcq[i].size() != 0)
        void'(srcq[i].pop_front());
      vin[i] = srcq[i].size() != 0;
      din[i*DATA_W +: DATA_W] = vin[i] ? srcq[i][0] : '0;
    end
    l2todr_req_valid_in = vin;
    l2todr_req_in = din;
  end

  // reference model: FIFO of accepted requests, pointer as int
  typedef struct {
    logic [63:0] d;
    int          s;
  } ent_t;

  ent_t        mq[$];
  int          rr = 0;
  bit          zeroed = 1'b1;
  int          cyc = 0;
  logic [63:0] dlog[$];
  int          slog[$];
  int          tlog[$];

  always @(negedge clk) begin : model
    int g, s, sz;
    bit any, enq, deq;
    logic [NREQ-1:0] er;
    ent_t e;
    cyc++;
    pop = l2todr_req_valid_in & ~l2todr_req_retry_in;
    if (reset) begin
      chk("rst_retry_in", 64'(l2todr_req_retry_in), 64'(ALL1));
      chk("rst_valid", 64'(l2todr_req_valid), 64'(0));
      chk("rst_req", l2todr_req, 64'(0));
      chk("rst_src", 64'(l2todr_req_src), 64'(0));
      mq.delete();
      rr = 0;
      zeroed = 1'b1;
    end else begin
      any = 1'b0;
      g = 0;
      for (int k = 0; k < NREQ; k++) begin
        s = (rr + k) % NREQ;
        if (!any && ((l2todr_req_valid_in >> s) & NREQ'(1)) != '0) begin
          g = s;
          any = 1'b1;
        end
      end
      sz = mq.size();
      enq = any && sz < 2;
      deq = sz != 0 && !l2todr_req_retry;
      er = enq ? (ALL1 & ~(NREQ'(1) << g)) : ALL1;
      chk("retry_in", 64'(l2todr_req_retry_in), 64'(er));
      chk("valid", 64'(l2todr_req_valid), 64'(sz != 0));
      if (sz != 0) begin
        chk("req", l2todr_req, mq[0].d);
        chk("src", 64'(l2todr_req_src), 64'(mq[0].s));
      end else if (zeroed) begin
        chk("req_clr", l2todr_req, 64'(0));
        chk("src_clr", 64'(l2todr_req_src), 64'(0));
      end
      if (deq) begin
        dlog.push_back(mq[0].d);
        slog.push_back(mq[0].s);
        tlog.push_back(cyc);
        void'(mq.pop_front());
      end
      if (enq) begin
        e.d = DATA_W'(l2todr_req_in >> (g*DATA_W));
        e.s = g;
        mq.push_back(e);
        rr = (g + 1) % NREQ;
        zeroed = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr_logs();
    dlog.delete();
    slog.delete();
    tlog.delete();
  endtask

  initial begin
    tick(2);
    chk("r0_retry_in", 64'(l2todr_req_retry_in), 64'hF);
    chk("r0_valid", 64'(l2todr_req_valid), 64'(0));

    // single source 2
    rst_nxt = 1'b0;
    srcq[2].push_back(64'hA5);
    tick(1);
    chk("s2_retry_in", 64'(l2todr_req_retry_in), 64'b1011);
    chk("s2_valid0", 64'(l2todr_req_valid), 64'(0));
    tick(1);
    chk("s2_valid1", 64'(l2todr_req_valid), 64'(1));
    chk("s2_req", l2todr_req, 64'hA5);
    chk("s2_src", 64'(l2todr_req_src), 64'(2));

    // pointer at 3, sources 0 and 3
    srcq[0].push_back(64'h100);
    srcq[3].push_back(64'h300);
    tick(1);
    chk("w_retry_in3", 64'(l2todr_req_retry_in), 64'b0111);
    tick(1);
    chk("w_retry_in0", 64'(l2todr_req_retry_in), 64'b1110);
    chk("w_src3", 64'(l2todr_req_src), 64'(3));
    chk("w_req3", l2todr_req, 64'h300);
    tick(1);
    chk("w_src0", 64'(l2todr_req_src), 64'(0));
    chk("w_req0", l2todr_req, 64'h100);
    tick(1);

    // fairness, pointer starts at 1
    clr_logs();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NREQ; i++)
        srcq[i].push_back(64'(i * 16 + k));
    tick(16);
    chk("fair_cnt", 64'(slog.size()), 64'(12));
    for (int k = 0; k < 12 && k < slog.size(); k++)
      chk($sformatf("fair_src%0d", k),
          64'(slog[k]), 64'((1 + k) % 4));
    if (tlog.size() == 12)
      chk("fair_rate", 64'(tlog[11] - tlog[0]), 64'(11));

    // reset, then backpressure with sources 0 and 1
    rst_nxt = 1'b1;
    tick(1);
    chk("r1_retry_in", 64'(l2todr_req_retry_in), 64'hF);
    rst_nxt = 1'b0;
    dretry_nxt = 1'b1;
    srcq[0].push_back(64'hB0);
    srcq[1].push_back(64'hB1);
    tick(1);
    chk("bp_valid0", 64'(l2todr_req_valid), 64'(0));
    chk("bp_retry_in0", 64'(l2todr_req_retry_in), 64'b1110);
    tick(1);
    chk("bp_retry_in1", 64'(l2todr_req_retry_in), 64'b1101);
    chk("bp_src_a", 64'(l2todr_req_src), 64'(0));
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("bp_full", 64'(l2todr_req_retry_in), 64'hF);
      chk("bp_hold_v", 64'(l2todr_req_valid), 64'(1));
      chk("bp_hold_s", 64'(l2todr_req_src), 64'(0));
      chk("bp_hold_d", l2todr_req, 64'hB0);
    end
    dretry_nxt = 1'b0;
    tick(1);
    chk("dr_src0", 64'(l2todr_req_src), 64'(0));
    tick(1);
    chk("dr_src1", 64'(l2todr_req_src), 64'(1));
    chk("dr_req1", l2todr_req, 64'hB1);
    tick(1);
    chk("dr_empty", 64'(l2todr_req_valid), 64'(0));

    // fill to two entries, then reset
    dretry_nxt = 1'b1;
    srcq[2].push_back(64'hC2);
    srcq[3].push_back(64'hC3);
    tick(3);
    chk("f2_valid", 64'(l2todr_req_valid), 64'(1));
    chk("f2_src", 64'(l2todr_req_src), 64'(2));
    chk("f2_retry_in", 64'(l2todr_req_retry_in), 64'hF);
    clr_logs();
    rst_nxt = 1'b1;
    tick(1);
    chk("f2_rst_valid", 64'(l2todr_req_valid), 64'(0));
    rst_nxt = 1'b0;
    dretry_nxt = 1'b0;
    tick(1);
    chk("f2_post_valid", 64'(l2todr_req_valid), 64'(0));
    chk("f2_post_req", l2todr_req, 64'(0));
    tick(3);
    chk("f2_no_stale", 64'(l2todr_req_valid), 64'(0));
    chk("f2_log", 64'(slog.size()), 64'(0));

    // stream 1..10 from source 1
    clr_logs();
    for (int k = 1; k <= 10; k++)
      srcq[1].push_back(64'(k));
    tick(14);
    chk("st_cnt", 64'(dlog.size()), 64'(10));
    for (int k = 0; k < 10 && k < dlog.size(); k++) begin
      chk($sformatf("st_d%0d", k), dlog[k], 64'(k + 1));
      chk($sformatf("st_s%0d", k), 64'(slog[k]), 64'(1));
    end
    if (tlog.size() == 10)
      chk("st_rate", 64'(tlog[9] - tlog[0]), 64'(9));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
